// File: rtl/lms_sequencer.sv
// Multi-cycle load/store-multiple sequencer: walks a register list low-to-high,
// one data-memory transfer per set bit, addresses stepped through the shared ALU.
module lms_sequencer #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int RIDX_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [DATA_W-1:0] base_addr,
  input  logic [NREG-1:0]   reg_list,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [2:0]        alu_opc,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src0,
  input  logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [RIDX_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [RIDX_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [NREG-1:0]   list_q, list_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic              store_q, store_d;

  logic [RIDX_W-1:0] idx;
  logic [NREG-1:0]   list_rem;
  logic              in_xfer;

  // Priority encoder: the descending scan leaves the lowest set bit in idx.
  always_comb begin
    idx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (list_q[i]) idx = RIDX_W'(i);
    end
  end

  // Clearing the lowest set bit is exactly clearing bit idx.
  assign list_rem = list_q & (list_q - NREG'(1));

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    addr_d  = addr_q;
    store_d = store_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          list_d  = reg_list;
          addr_d  = base_addr;
          store_d = is_store;
          state_d = (|reg_list) ? S_XFER : S_DONE;
        end
      end
      S_XFER: begin
        if (mem_ready) begin
          list_d  = list_rem;
          addr_d  = alu_out;
          state_d = (|list_rem) ? S_XFER : S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      list_q  <= '0;
      addr_q  <= '0;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      store_q <= store_d;
    end
  end

  // All strobes decode straight from the state flops, so reset drops them at once.
  assign in_xfer  = (state_q == S_XFER);
  assign busy     = (state_q != S_IDLE);
  assign stall    = busy | start;
  assign done     = (state_q == S_DONE);

  assign alu_opc  = 3'b000;
  assign alu_src0 = DATA_W'(1);
  assign alu_src1 = addr_q;

  assign mem_addr  = addr_q;
  assign mem_re    = in_xfer & ~store_q;
  assign mem_we    = in_xfer & store_q;
  assign rf_raddr  = mem_we ? idx : '0;
  assign mem_wdata = mem_we ? rf_rdata : '0;

  assign rf_we    = mem_re & mem_ready;
  assign rf_waddr = rf_we ? idx : '0;
  assign rf_wdata = rf_we ? mem_rdata : '0;

endmodule

// File: tb/tb_lms_sequencer.sv
// Bench for lms_sequencer: transfer-queue reference model checked every cycle,
// plus literal expectations for the directed LM/SM scenarios.
module tb_lms_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        is_store = 1'b0;
  logic [15:0] base_addr = '0;
  logic [7:0]  reg_list = '0;
  logic        busy, stall, done;
  logic [2:0]  alu_opc;
  logic [15:0] alu_src1, alu_src0, alu_out;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_re, mem_we;
  logic        mem_ready = 1'b1;
  logic [2:0]  rf_raddr, rf_waddr;
  logic [15:0] rf_rdata, rf_wdata;
  logic        rf_we;

  lms_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_store(is_store),
    .base_addr(base_addr), .reg_list(reg_list), .busy(busy), .stall(stall),
    .done(done), .alu_opc(alu_opc), .alu_src1(alu_src1), .alu_src0(alu_src0),
    .alu_out(alu_out), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  // Environment: ALU, data memory and register file.
  assign alu_out   = alu_src1 + alu_src0;
  assign mem_rdata = mem_ready ? mem_val(mem_addr) : 16'hDEAD;

  logic [15:0] seed_rf [8];
  logic [15:0] env_rf  [8];
  logic        load_en = 1'b0;
  assign rf_rdata = env_rf[rf_raddr];

  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < 8; i++) env_rf[i] <= seed_rf[i];
    end else if (rf_we) begin
      env_rf[rf_waddr] <= rf_wdata;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an instruction is a queue of register indices plus a running address.
  int          m_phase;   // 0 idle, 1 transferring, 2 completion cycle
  int          m_q[$];
  logic [15:0] m_addr;
  bit          m_store;
  logic [15:0] m_rf [8];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0;
      m_q.delete();
      m_addr  = '0;
      m_store = 1'b0;
    end else begin
      if (load_en) for (int i = 0; i < 8; i++) m_rf[i] = seed_rf[i];
      case (m_phase)
        0: if (start) begin
          m_store = is_store;
          m_addr  = base_addr;
          m_q.delete();
          for (int i = 0; i < 8; i++) if (reg_list[i]) m_q.push_back(i);
          m_phase = (m_q.size() != 0) ? 1 : 2;
        end
        1: if (mem_ready) begin
          if (!m_store) m_rf[m_q[0]] = mem_val(m_addr);
          void'(m_q.pop_front());
          m_addr = m_addr + 16'd1;
          if (m_q.size() == 0) m_phase = 2;
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("busy",  busy,  m_phase != 0);
      chk("done",  done,  m_phase == 2);
      chk("stall", stall, (m_phase != 0) || start);
      chk("mem_re", mem_re, m_phase == 1 && !m_store);
      chk("mem_we", mem_we, m_phase == 1 && m_store);
      chk("rf_we",  rf_we,  m_phase == 1 && !m_store && mem_ready);
      chk("alu_opc", alu_opc, 3'b000);
      chk("alu_src0", alu_src0, 16'h0001);
      chk("alu_src1", alu_src1, m_addr);
      if (m_phase == 1) begin
        chk("mem_addr", mem_addr, m_addr);
        if (m_store) begin
          chk("rf_raddr", rf_raddr, m_q[0]);
          chk("mem_wdata", mem_wdata, m_rf[m_q[0]]);
        end else if (mem_ready) begin
          chk("rf_waddr", rf_waddr, m_q[0]);
          chk("rf_wdata", rf_wdata, mem_val(m_addr));
        end
      end
    end
  end

  // Transfer log used by the literal checks.
  int          cyc = 0;
  int          t0 = 0;
  int          done_cyc = -1;
  int          n_rfwe = 0;
  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];
  int          log_reg[$];
  int          log_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n) begin
      if ((mem_re || mem_we) && mem_ready) begin
        log_addr.push_back(mem_addr);
        log_reg.push_back(mem_we ? int'(rf_raddr) : int'(rf_waddr));
        log_data.push_back(mem_we ? mem_wdata : rf_wdata);
        log_cyc.push_back(cyc - t0);
      end
      if (rf_we) n_rfwe++;
      if (done && done_cyc < 0) done_cyc = cyc - t0;
    end
  end

  bit rand_ready = 1'b0;
  bit ready_script[$];

  always @(posedge clk) begin
    #1;
    if (ready_script.size() != 0) mem_ready = ready_script.pop_front();
    else if (rand_ready)          mem_ready = ($urandom_range(0, 2) != 0);
    else                          mem_ready = 1'b1;
  end

  task automatic clear_log();
    log_addr.delete(); log_data.delete(); log_reg.delete(); log_cyc.delete();
    n_rfwe = 0;
    done_cyc = -1;
  endtask

  task automatic run(input bit st, input logic [15:0] base, input logic [7:0] lst, input bit junk);
    int k;
    @(posedge clk); #1;
    clear_log();
    is_store = st; base_addr = base; reg_list = lst; start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    if (junk) begin
      is_store = ~st; base_addr = 16'($urandom); reg_list = 8'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
    k = 0;
    while (done_cyc < 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (done_cyc < 0) begin
      n_bad++;
      $display("FAIL timeout: got no done expected done within 400 cycles");
    end
    @(posedge clk); #2;
    $display("xfer %s list=%h base=%h transfers=%0d done_cycle=%0d",
             st ? "SM" : "LM", lst, base, log_addr.size(), done_cyc);
  endtask

  task automatic chk_xfer(input int i, input logic [15:0] a, input int r, input int c);
    if (log_addr.size() > i) begin
      chk($sformatf("xfer%0d_addr", i), log_addr[i], a);
      chk($sformatf("xfer%0d_reg", i), r, log_reg[i]);
      chk($sformatf("xfer%0d_cycle", i), log_cyc[i], c);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL xfer%0d_missing: got %0d transfers expected more than %0d", i, log_addr.size(), i);
    end
  endtask

  task automatic load_seeds();
    for (int i = 0; i < 8; i++) seed_rf[i] = 16'h1000 + 16'(i) * 16'h0111;
    @(posedge clk); #1 load_en = 1'b1;
    @(posedge clk); #1 load_en = 1'b0;
  endtask

  initial begin
    // Reset values while reset_n is held low
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_strobes", {mem_re, mem_we, rf_we}, 3'b000);
    chk("rst_alu_opc", alu_opc, 3'b000);
    chk("rst_alu_src0", alu_src0, 16'h0001);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_data", {mem_wdata, rf_wdata}, 32'h0);
    @(posedge clk); #2 reset_n = 1'b1;
    load_seeds();

    // LM two registers
    run(1'b0, 16'h0100, 8'h05, 1'b0);
    chk("lm05_count", log_addr.size(), 2);
    chk_xfer(0, 16'h0100, 0, 1);
    chk_xfer(1, 16'h0101, 2, 2);
    chk("lm05_done", done_cyc, 3);

    // SM all eight
    load_seeds();
    run(1'b1, 16'h0200, 8'hFF, 1'b0);
    chk("smff_count", log_addr.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk_xfer(i, 16'h0200 + 16'(i), i, i + 1);
      if (log_data.size() > i) chk("smff_data", log_data[i], 16'h1000 + 16'(i) * 16'h0111);
    end
    chk("smff_done", done_cyc, 9);
    chk("smff_rfwe", n_rfwe, 0);

    // Empty list
    run(1'b0, 16'h0300, 8'h00, 1'b0);
    chk("empty_count", log_addr.size(), 0);
    chk("empty_done", done_cyc, 1);

    // Address wrap
    run(1'b0, 16'hFFFF, 8'h03, 1'b0);
    chk_xfer(0, 16'hFFFF, 0, 1);
    chk_xfer(1, 16'h0000, 1, 2);
    chk("wrap_done", done_cyc, 3);

    // Memory wait states on the second store
    load_seeds();
    ready_script = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    run(1'b1, 16'h0300, 8'h07, 1'b0);
    chk_xfer(0, 16'h0300, 0, 1);
    chk_xfer(1, 16'h0301, 1, 5);
    chk_xfer(2, 16'h0302, 2, 6);
    chk("wait_done", done_cyc, 7);

    // Asynchronous reset in the middle of the second of four loads
    @(posedge clk); #1;
    clear_log();
    is_store = 1'b0; base_addr = 16'h0400; reg_list = 8'h0F; start = 1'b1; t0 = cyc;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_strobes", {mem_re, mem_we, rf_we, done}, 4'b0000);
    chk("arst_mem_addr", mem_addr, 16'h0000);
    chk("arst_count", log_addr.size(), 1);
    @(posedge clk); @(posedge clk); #2 reset_n = 1'b1;
    run(1'b0, 16'h0500, 8'h30, 1'b0);
    chk_xfer(0, 16'h0500, 4, 1);
    chk_xfer(1, 16'h0501, 5, 2);
    chk("post_rst_done", done_cyc, 3);

    // Randomized instructions with random memory wait states and ignored restarts
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] lst;
      lst = (n % 9 == 0) ? 8'h00 : 8'($urandom);
      if (n % 10 == 3) load_seeds();
      run(1'($urandom_range(0, 1)), 16'($urandom), lst, 1'($urandom_range(0, 1)));
      chk("rnd_count", log_addr.size(), $countones(lst));
    end
    rand_ready = 1'b0;

    for (int i = 0; i < 8; i++) chk($sformatf("final_r%0d", i), env_rf[i], m_rf[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lms_sequencer.md
Name: lms_sequencer

Overview:
- Multi-cycle controller for the IITB-RISC load-multiple (LM) and store-multiple (SM) instructions.
- Walks the 8-bit register list from the lowest index to the highest, one memory transfer per set bit.
- Generates each transfer address by driving the shared execute-stage ALU with its no-flag add opcode (3'b000), so C/Z flags are never disturbed.
- Stalls fetch/decode while busy and moves data between the register file and data memory.

Parameters:
- DATA_W, 16, datapath/address width
- NREG, 8, register-list width / register count
- RIDX_W, 3, register index width (log2 NREG)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request from decode; sampled only in IDLE
- is_store  in  1  0 = LM, 1 = SM; sampled with start
- base_addr  in  DATA_W  first transfer address; sampled with start
- reg_list  in  NREG  bit i set = transfer register Ri; sampled with start
- busy  out  1  high in any state other than IDLE
- stall  out  1  pipeline freeze to fetch/decode
- done  out  1  one-cycle completion pulse
- alu_opc  out  3  constant 3'b000 (add, no flag update)
- alu_src1  out  DATA_W  current address register
- alu_src0  out  DATA_W  constant 16'h0001
- alu_out  in  DATA_W  ALU sum = next address
- mem_addr  out  DATA_W  data memory address
- mem_re  out  1  memory read strobe (LM)
- mem_we  out  1  memory write strobe (SM)
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  load data, valid when mem_ready=1
- mem_ready  in  1  memory completes current access this cycle
- rf_raddr  out  RIDX_W  register read index (SM)
- rf_rdata  in  DATA_W  register read data, combinational
- rf_we  out  1  register write enable (LM)
- rf_waddr  out  RIDX_W  register write index
- rf_wdata  out  DATA_W  register write data

Behaviour:
- States: IDLE, XFER, DONE. Internal registers: list_q[NREG-1:0], addr_q[15:0], store_q.
- Reset (asynchronous, any state, including mid-transfer):
  - State goes to IDLE; list_q, addr_q and store_q clear to 0.
  - busy, stall, done, mem_re, mem_we and rf_we go to 0.
  - All address/data outputs go to 0, except alu_opc = 3'b000 and alu_src0 = 16'h0001.
- IDLE, start=1:
  - Latch reg_list, base_addr and is_store.
  - If reg_list != 0, go to XFER; otherwise go to DONE with no memory access.
  - start in any other state is ignored; decode must hold the instruction while stall=1.
- stall = (state != IDLE) | start. The combinational term covers the accept cycle.
- XFER:
  - idx = lowest set bit of list_q (priority encoder, bit 0 highest priority). mem_addr = addr_q.
  - SM: mem_we=1, rf_raddr=idx, mem_wdata=rf_rdata.
  - LM: mem_re=1. When mem_ready=1, also drive rf_we=1, rf_waddr=idx, rf_wdata=mem_rdata in that same cycle.
  - alu_src1 = addr_q at all times.
  - While mem_ready=0: hold all strobes, mem_addr, idx and list_q; no rf_we.
  - On mem_ready=1 (clock edge): clear bit idx in list_q and set addr_q <= alu_out.
  - If the cleared list is zero, go to DONE; otherwise stay in XFER with the next idx.
- DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE.
- Latency with mem_ready tied to 1: N transfers occupy cycles 1..N after start, done asserts in cycle N+1, and IDLE is reached at cycle N+2. Empty list: done in cycle 1.
- Addresses are word-granular and 16-bit modulo: 0xFFFF + 1 = 0x0000. The ALU carry is ignored.
- rf_we and mem_we are never high together. Strobes are 0 outside XFER.
- Flag state of the ALU is never altered because alu_opc is fixed at the no-flag add.

Test Plan:
- LM, reg_list=8'h05, base=0x0100, mem_ready=1: cycle1 mem_re at 0x0100 with rf_we R0; cycle2 at 0x0101 with rf_we R2; cycle3 done=1; busy high for cycles 1-3.
- SM, reg_list=8'hFF, base=0x0200, R0..R7 preloaded: mem_we at 0x0200..0x0207 with data R0..R7 in ascending order; done in cycle 9; rf_we never asserted.
- reg_list=8'h00: no mem_re/mem_we, done=1 in cycle 1, IDLE in cycle 2; stall high only for cycles 0-1.
- Wrap, base=0xFFFF, reg_list=8'h03, LM: addresses 0xFFFF then 0x0000; writes to R0 then R1.
- mem_ready held 0 for 3 cycles on the second SM transfer: mem_addr, mem_we and rf_raddr stable for 4 cycles; third transfer follows one cycle after ready.
- reset_n low during the second of four LM transfers: all strobes and busy drop immediately (asynchronous); a new start after release runs the full new list from its own base.
